// File: rtl/lcd8080_pkg.sv
// lcd8080_pkg: shared constants for the AHB to 8080 LCD bridge.
// Register indices, FSM states, CTRL fields, queue entry type.
package lcd8080_pkg;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_TWRL_LSB = 0;
  localparam int CTRL_TWRH_LSB = 4;
  localparam int CTRL_RST_BIT  = 8;
  localparam int CTRL_W        = 9;

  localparam logic [31:0] CTRL_RESET_DEF = 32'h0000_0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRL,
    ST_WRH
  } lcd_state_e;

  typedef struct packed {
    logic        rs;
    logic [15:0] db;
  } lcd_entry_t;

endpackage

// File: rtl/ahb_lcd8080_if.sv
// ahb_lcd8080_if: AHB-Lite slave port bundle (matrix side = master).
// Ports: HSEL/HREADY/HTRANS/HSIZE/HWRITE/HADDR/HWDATA in, HREADYOUT/HRESP/HRDATA out.
interface ahb_lcd8080_if;
  logic        HSEL;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HREADY, HTRANS, HSIZE,
    input  HWRITE, HADDR, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HREADY, HTRANS, HSIZE,
    output HWRITE, HADDR, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/lcd8080_fifo.sv
// lcd8080_fifo: synchronous FIFO, power-of-two depth, level counter.
// Ports: clk_i, rst_ni, push_i, pop_i, wdata_i, rdata_o, full_o, empty_o, level_o.
module lcd8080_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ahb_lcd8080.sv
// ahb_lcd8080: AHB-Lite slave queuing CMD/DATA writes into 8080 write cycles.
// Ports: HCLK, HRESETn, ahb (slave bundle), LCD_CS_N/RS/WR_N/RD_N/RST_N, LCD_DB.
module ahb_lcd8080
  import lcd8080_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] CTRL_RESET = CTRL_RESET_DEF
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  ahb_lcd8080_if.slave ahb,
  output logic         LCD_CS_N,
  output logic         LCD_RS,
  output logic         LCD_WR_N,
  output logic         LCD_RD_N,
  output logic         LCD_RST_N,
  output logic [15:0]  LCD_DB
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              act_q, wr_q;
  logic [1:0]        idx_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              fifo_wr, push, pop;
  logic              full, empty, busy;
  logic [LW-1:0]     level;
  lcd_entry_t        wentry, rentry;
  lcd_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        twrl_q, twrl_d;
  logic [3:0]        twrh_q, twrh_d;
  logic              cs_n_q, cs_n_d;
  logic              rs_q, rs_d;
  logic              wr_n_q, wr_n_d;
  logic [15:0]       db_q, db_d;
  logic              unused_bus;

  assign unused_bus = ^{ahb.HSIZE, ahb.HADDR[31:4],
                        ahb.HADDR[1:0], ahb.HWDATA[31:16],
                        ahb.HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      act_q <= 1'b0;
      wr_q  <= 1'b0;
      idx_q <= '0;
    end else if (ahb.HREADY) begin
      act_q <= ahb.HSEL && ahb.HTRANS[1];
      wr_q  <= ahb.HWRITE;
      idx_q <= ahb.HADDR[3:2];
    end
  end

  // CMD and DATA are the two registers with idx[1]=0.
  assign fifo_wr = act_q && wr_q && !idx_q[1];
  assign push    = fifo_wr && !full;
  assign wentry  = '{rs: (idx_q == REG_DATA),
                     db: ahb.HWDATA[15:0]};

  assign ahb.HREADYOUT = !(fifo_wr && full);
  assign ahb.HRESP     = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q <= CTRL_RESET[CTRL_W-1:0];
    end else if (act_q && wr_q && idx_q == REG_CTRL) begin
      ctrl_q <= ahb.HWDATA[CTRL_W-1:0];
    end
  end

  assign busy = (state_q != ST_IDLE) || !empty;

  always_comb begin
    ahb.HRDATA = '0;
    if (act_q && !wr_q) begin
      unique case (1'b1)
        idx_q == REG_CTRL: ahb.HRDATA[CTRL_W-1:0] = ctrl_q;
        idx_q == REG_STATUS: begin
          ahb.HRDATA[0]    = busy;
          ahb.HRDATA[1]    = full;
          ahb.HRDATA[2]    = empty;
          ahb.HRDATA[12:8] = 5'(level);
        end
        default: ahb.HRDATA = '0;
      endcase
    end
  end

  lcd8080_fifo #(
    .WIDTH($bits(lcd_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .rdata_o (rentry),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      twrl_q  <= '0;
      twrh_q  <= '0;
      cs_n_q  <= 1'b1;
      rs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      twrl_q  <= twrl_d;
      twrh_q  <= twrh_d;
      cs_n_q  <= cs_n_d;
      rs_q    <= rs_d;
      wr_n_q  <= wr_n_d;
      db_q    <= db_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    twrl_d  = twrl_q;
    twrh_d  = twrh_q;
    cs_n_d  = cs_n_q;
    rs_d    = rs_q;
    wr_n_d  = wr_n_q;
    db_d    = db_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: pop = !empty;
      ST_SETUP: begin
        state_d = ST_WRL;
        wr_n_d  = 1'b0;
        cnt_d   = '0;
      end
      ST_WRL: begin
        if (cnt_q == twrl_q) begin
          state_d = ST_WRH;
          wr_n_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WRH: begin
        if (cnt_q != twrh_q) begin
          cnt_d = cnt_q + 4'd1;
        end else if (!empty) begin
          pop = 1'b1;
        end else begin
          cs_n_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
    // Timing is latched per entry so CTRL writes apply at the next pop.
    if (pop) begin
      state_d = ST_SETUP;
      cs_n_d  = 1'b0;
      rs_d    = rentry.rs;
      db_d    = rentry.db;
      twrl_d  = ctrl_q[CTRL_TWRL_LSB +: 4];
      twrh_d  = ctrl_q[CTRL_TWRH_LSB +: 4];
    end
  end

  assign LCD_CS_N  = cs_n_q;
  assign LCD_RS    = rs_q;
  assign LCD_WR_N  = wr_n_q;
  assign LCD_DB    = db_q;
  assign LCD_RD_N  = 1'b1;
  assign LCD_RST_N = ctrl_q[CTRL_RST_BIT];

endmodule

// File: tb/tb_ahb_lcd8080.sv
// tb_ahb_lcd8080: scoreboard bench for ahb_lcd8080.
// Queues expected 8080 writes on stimulus, checks them at each WR_N rise.
module tb_ahb_lcd8080;

  typedef struct {
    logic        rs;
    logic [15:0] db;
    int          lo;
    int          hi;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cs_n, rs, wr_n, rd_n, lcd_rst_n;
  logic [15:0] db;

  ahb_lcd8080_if ahb();
  assign ahb.HREADY = ahb.HREADYOUT;

  ahb_lcd8080 #(.FIFO_DEPTH(8)) dut (
    .HCLK      (clk),
    .HRESETn   (rst_n),
    .ahb       (ahb),
    .LCD_CS_N  (cs_n),
    .LCD_RS    (rs),
    .LCD_WR_N  (wr_n),
    .LCD_RD_N  (rd_n),
    .LCD_RST_N (lcd_rst_n),
    .LCD_DB    (db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   twrl_m = 1;
  int   twrh_m = 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic r, input logic [15:0] d);
    exp_t e;
    e.rs = r;
    e.db = d;
    e.lo = twrl_m + 1;
    e.hi = twrh_m + 1;
    sb.push_back(e);
  endtask

  task automatic ahb_wr(input logic [1:0] idx,
                        input logic [31:0] d,
                        output int st);
    st = 0;
    @(posedge clk); #1;
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b1;
    ahb.HADDR  = 32'h4000_0000 | {28'd0, idx, 2'b00};
    @(posedge clk); #1;
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWDATA = d;
    while (!ahb.HREADYOUT && st < 500) begin
      @(posedge clk); #1;
      st++;
    end
    if (st >= 500) check("hready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic ahb_rd(input logic [1:0] idx,
                        output logic [31:0] d);
    @(posedge clk); #1;
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = 32'h4000_0000 | {28'd0, idx, 2'b00};
    @(posedge clk); #1;
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    d = ahb.HRDATA;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || cs_n !== 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_wr_fall();
    int n = 0;
    while (wr_n !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (wr_n !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wr_fall", 32'(n < 200), 32'd1);
  endtask

  // Monitor: pops the scoreboard at each WR_N rise and checks widths.
  logic prev_wr, prev_cs, hi_act;
  int   lo_cnt, hi_cnt, last_hi, pulses;
  exp_t me;

  initial begin
    prev_wr = 1'b1;
    prev_cs = 1'b1;
    hi_act  = 1'b0;
    lo_cnt  = 0;
    hi_cnt  = 0;
    last_hi = 0;
    pulses  = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 1'b1;
      prev_cs = 1'b1;
      hi_act  = 1'b0;
      lo_cnt  = 0;
    end else begin
      if (prev_wr && !wr_n) begin
        pulses++;
        check("cs_at_fall", 32'(cs_n), 32'd0);
        check("pulse_expected", 32'(sb.size() != 0), 32'd1);
        if (hi_act) check("hi_b2b", 32'(hi_cnt), 32'(last_hi + 1));
        hi_act = 1'b0;
        lo_cnt = 0;
      end
      if (!wr_n) lo_cnt++;
      if (!prev_wr && wr_n) begin
        if (sb.size() != 0) begin
          me = sb.pop_front();
          check("rs", 32'(rs), 32'(me.rs));
          check("db", 32'(db), 32'(me.db));
          check("wr_low", 32'(lo_cnt), 32'(me.lo));
          last_hi = me.hi;
          hi_act  = 1'b1;
          hi_cnt  = 1;
        end
      end else if (hi_act && wr_n && !cs_n) begin
        hi_cnt++;
      end
      if (hi_act && !prev_cs && cs_n) begin
        check("wr_high", 32'(hi_cnt), 32'(last_hi));
        hi_act = 1'b0;
      end
      prev_wr = wr_n;
      prev_cs = cs_n;
    end
  end

  logic [31:0] rd;
  int          st;
  int          exp_lvl;
  int          p0;

  initial begin
    rst_n      = 1'b1;
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HSIZE  = 3'b010;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = '0;
    ahb.HWDATA = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lcd", 32'({cs_n, rs, wr_n, rd_n, lcd_rst_n}), 32'b10110);
    check("rst_db", 32'(db), 32'd0);
    check("rst_bus", 32'({ahb.HREADYOUT, ahb.HRESP}), 32'b10);
    check("rst_hrdata", ahb.HRDATA, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    ahb_rd(2'd2, rd); check("ctrl_rst", rd, 32'h11);
    ahb_rd(2'd3, rd); check("status_rst", rd, 32'h004);
    ahb_rd(2'd1, rd); check("data_rd0", rd, 32'h0);

    // Single command at reset timing.
    sb_push(1'b0, 16'h002C);
    ahb_wr(2'd0, 32'h0000_002C, st);
    @(negedge clk); check("cs_e0", 32'(cs_n), 32'd1);
    @(negedge clk); check("cs_e1", 32'(cs_n), 32'd0);
    check("rs_cmd", 32'(rs), 32'd0);
    check("db_cmd", 32'(db), 32'h2C);
    check("wr_e1", 32'(wr_n), 32'd1);
    @(negedge clk); check("wr_e2", 32'(wr_n), 32'd0);
    wait_drain();

    // New timing plus panel reset release.
    ahb_wr(2'd2, 32'h0000_0132, st);
    twrl_m = 2;
    twrh_m = 3;
    @(negedge clk); check("lcd_rst_n", 32'(lcd_rst_n), 32'd1);
    ahb_rd(2'd2, rd); check("ctrl_rd", rd, 32'h132);
    sb_push(1'b1, 16'hF800);
    ahb_wr(2'd1, 32'h0000_F800, st);
    wait_drain();

    // Slow timing so the burst fills the queue.
    ahb_wr(2'd2, 32'h0000_01FF, st);
    twrl_m = 15;
    twrh_m = 15;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      sb_push(1'b1, d);
      ahb_wr(2'd1, {16'hDEAD, d}, st);
      if (i == 8) check("stall_w9", 32'(st), 32'd0);
      if (i == 9) check("stall_w10", 32'(st > 0), 32'd1);
    end
    wait_wr_fall();
    exp_lvl = sb.size() - 1;
    ahb_rd(2'd3, rd);
    check("mid_busy", 32'(rd[0]), 32'd1);
    check("mid_level", 32'(rd[12:8]), 32'(exp_lvl));
    check("mid_full", 32'(rd[1]), 32'(exp_lvl == 8));
    wait_drain();
    ahb_rd(2'd3, rd); check("status_drain", rd, 32'h004);

    // Reset in the middle of a WR low phase.
    sb_push(1'b1, 16'h1234);
    ahb_wr(2'd1, 32'h0000_1234, st);
    wait_wr_fall();
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_wr", 32'(wr_n), 32'd1);
    check("arst_cs", 32'(cs_n), 32'd1);
    check("arst_db", 32'(db), 32'd0);
    check("arst_lrst", 32'(lcd_rst_n), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    twrl_m = 1;
    twrh_m = 1;
    p0 = pulses;
    ahb_rd(2'd3, rd); check("status_arst", rd, 32'h004);
    ahb_rd(2'd2, rd); check("ctrl_arst", rd, 32'h11);
    repeat (30) @(negedge clk);
    check("no_stale", 32'(pulses - p0), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
